exec_core: RTL and testbench

//   Execute core of the 8-bit single-cycle processor: instruction decode, ALU and a data cache.

---
 rtl/exec_core.sv | 155 +++++++++++++++
 tb/tb_exec_core.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/exec_core.sv
// Execute core: decode, ALU, direct-mapped write-through data cache; zero latency, only cache state is sequential.
// No backpressure: main memory is combinational, so every instruction completes in its own cycle.
module exec_core #(
  parameter int LINES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic [7:0] rd1,
  input  logic [7:0] rd2,
  output logic       reg_write,
  output logic       reg_wr_sel,
  output logic [7:0] reg_wr_data,
  output logic       br_taken,
  output logic       jump,
  output logic [7:0] pc_imm,
  output logic [7:0] alu_out,
  output logic       zero,
  output logic       mm_rd,
  output logic       mm_wr,
  output logic [7:0] mm_addr,
  output logic [7:0] mm_wdata,
  input  logic [7:0] mm_rdata
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 8 - IDXW;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_LI   = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;

  logic [2:0] op;
  logic [7:0] sext3;
  logic [7:0] alu_res;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_j;
  logic       wr_en;

  assign op    = instr[7:5];
  assign sext3 = {{5{instr[2]}}, instr[2:0]};

  always_comb begin
    alu_res = 8'd0;
    wr_en   = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    case (op)
      OP_R: begin
        wr_en = 1'b1;
        case (instr[2:1])
          2'b00:   alu_res = rd1 + rd2;
          2'b01:   alu_res = rd1 - rd2;
          2'b10:   alu_res = rd1 & rd2;
          default: alu_res = rd1 | rd2;
        endcase
      end
      OP_ADDI: begin
        wr_en   = 1'b1;
        alu_res = rd1 + sext3;
      end
      OP_J: is_j = 1'b1;
      OP_LI: begin
        wr_en   = 1'b1;
        alu_res = 8'd0 + {4'b0, instr[3:0]};
      end
      OP_LW: begin
        wr_en   = 1'b1;
        is_lw   = 1'b1;
        alu_res = rd1 + sext3;
      end
      OP_SW: begin
        is_sw   = 1'b1;
        alu_res = rd1 + sext3;
      end
      OP_BEQ: begin
        is_beq  = 1'b1;
        alu_res = rd1 - rd2;
      end
      default: alu_res = 8'd0;
    endcase
  end

  logic [7:0]      data_q [LINES];
  logic [7:0]      data_d [LINES];
  logic [TAGW-1:0] tag_q  [LINES];
  logic [TAGW-1:0] tag_d  [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic            fill_en;
  logic [7:0]      fill_dat;
  logic [7:0]      load_dat;

  assign idx      = alu_res[IDXW-1:0];
  assign tag      = alu_res[7:IDXW];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign load_dat = hit ? data_q[idx] : mm_rdata;
  // Stores allocate too, so a later load of the same address hits.
  assign fill_en  = !rst && ((is_lw && !hit) || is_sw);
  assign fill_dat = is_sw ? rd2 : mm_rdata;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      data_d[idx]  = fill_dat;
      tag_d[idx]   = tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  always_comb begin
    reg_write   = wr_en && !rst;
    reg_wr_sel  = (op == OP_LI) ? instr[4] : instr[3];
    reg_wr_data = is_lw ? load_dat : alu_res;
    br_taken    = is_beq && (alu_res == 8'd0) && !rst;
    jump        = is_j && !rst;
    pc_imm      = 8'd0;
    if (is_j)   pc_imm = {3'b0, instr[4:0]};
    if (is_beq) pc_imm = {5'b0, instr[2:0]};
    alu_out     = alu_res;
    zero        = (alu_res == 8'd0);
    mm_rd       = is_lw && !hit && !rst;
    mm_wr       = is_sw && !rst;
    mm_addr     = alu_res;
    mm_wdata    = rd2;
  end

endmodule

// File: tb/tb_exec_core.sv
// Randomized bench for exec_core with an address-keyed cache model and a backing memory array.
module tb_exec_core;
  localparam int LINES = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr = 8'hE0;
  logic [7:0] rd1 = 8'h00;
  logic [7:0] rd2 = 8'h00;
  logic [7:0] mm_rdata = 8'h00;
  logic       reg_write, reg_wr_sel, br_taken, jump, zero, mm_rd, mm_wr;
  logic [7:0] reg_wr_data, pc_imm, alu_out, mm_addr, mm_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  bit         mv  [LINES];
  logic [7:0] ma  [LINES];
  logic [7:0] md  [LINES];

  always #5 clk = ~clk;

  exec_core #(.LINES(LINES)) dut (
    .clk(clk), .rst(rst), .instr(instr), .rd1(rd1), .rd2(rd2),
    .reg_write(reg_write), .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data),
    .br_taken(br_taken), .jump(jump), .pc_imm(pc_imm), .alu_out(alu_out), .zero(zero),
    .mm_rd(mm_rd), .mm_wr(mm_wr), .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One instruction: drive at negedge, compare against the model, then advance the model's cache.
  task automatic step(input logic r, input logic [7:0] i, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] mrd, input bit use_mem);
    int   op, line;
    logic [7:0] ea, res, wd, pc;
    bit   hit, wr, sel, br, jmp, erd, ewr, has_alu;
    @(negedge clk);
    rst = r; instr = i; rd1 = a; rd2 = b;
    op   = int'(i[7:5]);
    ea   = a + {{5{i[2]}}, i[2:0]};
    line = int'(ea) % LINES;
    hit  = mv[line] && (ma[line] == ea);
    mm_rdata = use_mem ? mem[ea] : mrd;
    #1;
    res = 8'd0; wd = 8'd0; pc = 8'd0;
    wr = 0; br = 0; jmp = 0; erd = 0; ewr = 0; has_alu = 1;
    sel = i[3];
    case (op)
      0: begin
        case (int'(i[2:1]))
          0: res = a + b;
          1: res = a - b;
          2: res = a & b;
          default: res = a | b;
        endcase
        wr = 1; wd = res;
      end
      1: begin res = ea; wr = 1; wd = res; end
      2: begin jmp = 1; pc = {3'b000, i[4:0]}; has_alu = 0; end
      3: begin res = {4'h0, i[3:0]}; wr = 1; wd = res; sel = i[4]; end
      4: begin res = ea; wr = 1; erd = !hit; wd = hit ? md[line] : mm_rdata; end
      5: begin res = ea; ewr = 1; end
      6: begin res = a - b; br = (res == 8'd0); pc = {5'b0, i[2:0]}; end
      default: has_alu = 0;
    endcase
    if (wr) check("wr_data", reg_wr_data, wd);
    if (r) begin wr = 0; br = 0; jmp = 0; erd = 0; ewr = 0; end
    check("reg_write", reg_write, wr);
    check("reg_wr_sel", reg_wr_sel, sel);
    check("br_taken", br_taken, br);
    check("jump", jump, jmp);
    check("pc_imm", pc_imm, pc);
    check("mm_rd", mm_rd, erd);
    check("mm_wr", mm_wr, ewr);
    check("mm_wdata", mm_wdata, b);
    if (has_alu) begin
      check("alu_out", alu_out, res);
      check("zero", zero, res == 8'd0);
      check("mm_addr", mm_addr, res);
    end
    if (r) begin
      for (int k = 0; k < LINES; k++) mv[k] = 0;
    end else if (op == 4 && !hit) begin
      mv[line] = 1; ma[line] = ea; md[line] = mm_rdata;
    end else if (op == 5) begin
      mv[line] = 1; ma[line] = ea; md[line] = b; mem[ea] = b;
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    for (int k = 0; k < LINES; k++) begin mv[k] = 0; ma[k] = 8'h00; md[k] = 8'h00; end

    step(1'b1, 8'hE0, 8'h00, 8'h00, 8'h00, 0);
    step(1'b1, 8'h40, 8'h00, 8'h00, 8'h00, 0);
    check("rst_jump", jump, 1'b0);

    step(1'b0, 8'h08, 8'h7F, 8'h01, 8'h00, 0);
    check("add_lit", reg_wr_data, 8'h80);
    step(1'b0, 8'h0A, 8'h00, 8'h01, 8'h00, 0);
    check("sub_lit", reg_wr_data, 8'hFF);
    step(1'b0, 8'h7A, 8'h00, 8'h00, 8'h00, 0);
    check("li_lit", reg_wr_data, 8'h0A);
    step(1'b0, 8'hC5, 8'h33, 8'h33, 8'h00, 0);
    check("beq_lit", br_taken, 1'b1);
    step(1'b0, 8'hC5, 8'h33, 8'h34, 8'h00, 0);
    check("bne_lit", br_taken, 1'b0);

    step(1'b0, 8'h80, 8'h12, 8'h00, 8'hAB, 0);
    check("lw_miss_lit", mm_rd, 1'b1);
    step(1'b0, 8'h80, 8'h12, 8'h00, 8'h00, 0);
    check("lw_hit_lit", reg_wr_data, 8'hAB);
    step(1'b0, 8'hA0, 8'h03, 8'h5C, 8'h00, 0);
    check("sw_wr_lit", mm_wr, 1'b1);
    step(1'b0, 8'h80, 8'h03, 8'h00, 8'h00, 0);
    check("sw_hit_lit", reg_wr_data, 8'h5C);
    step(1'b0, 8'h80, 8'h0B, 8'h00, 8'h77, 0);
    check("conflict_miss_lit", mm_rd, 1'b1);

    step(1'b0, 8'h80, 8'h12, 8'h00, 8'h00, 0);
    step(1'b1, 8'h80, 8'h12, 8'h00, 8'h00, 0);
    step(1'b1, 8'hA0, 8'h12, 8'h99, 8'h00, 0);
    step(1'b0, 8'h80, 8'h12, 8'h00, 8'h21, 0);
    check("post_rst_miss_lit", mm_rd, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 63) == 0), 8'($urandom), 8'($urandom_range(0, 23)),
           8'($urandom), 8'h00, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
